// File: rtl/hdmi_video_timing.sv
// Raster timing generator for the HDMI output path.
// Produces registered pixel coordinates, active-video flag and frame start for the
// pixel-colour stage, plus syncs/de delayed one clock to line up with its
// registered r/g/b, and a channel select that can only change at frame start.
module hdmi_video_timing #(
   parameter int H_ACTIVE = 1280,
   parameter int H_FP     = 110,
   parameter int H_SYNC   = 40,
   parameter int H_BP     = 220,
   parameter int V_ACTIVE = 720,
   parameter int V_FP     = 5,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 20,
   parameter int SYNC_POL = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  channel_select_in,
   output logic [11:0] px_x,
   output logic [11:0] px_y,
   output logic        data_en,
   output logic        frame_start,
   output logic [1:0]  channel_select,
   output logic        hdmi_hsync,
   output logic        hdmi_vsync,
   output logic        hdmi_de
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

   // Decode bounds are one bit wider so an end bound of 4096 is representable.
   localparam logic [12:0] H_ACT_END = 13'(H_ACTIVE);
   localparam logic [12:0] HS_BEG    = 13'(H_ACTIVE + H_FP);
   localparam logic [12:0] HS_END    = 13'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [12:0] V_ACT_END = 13'(V_ACTIVE);
   localparam logic [12:0] VS_BEG    = 13'(V_ACTIVE + V_FP);
   localparam logic [12:0] VS_END    = 13'(V_ACTIVE + V_FP + V_SYNC);

   localparam logic SYNC_ON  = (SYNC_POL != 0);
   localparam logic SYNC_OFF = ~SYNC_ON;

   // True when cnt lies in the half-open window [lo, hi).
   function automatic logic in_window(input logic [11:0] cnt,
                                      input logic [12:0] lo,
                                      input logic [12:0] hi);
      return ({1'b0, cnt} >= lo) && ({1'b0, cnt} < hi);
   endfunction

   logic [11:0] h_cnt;
   logic [11:0] v_cnt;
   logic [11:0] h_nxt;
   logic [11:0] v_nxt;
   logic        act_nxt;
   logic        hs_nxt;
   logic        vs_nxt;
   logic        fs_nxt;
   logic        hsync_p0;
   logic        vsync_p0;

   // Next raster position: h wraps at line end, v steps only on that wrap.
   always_comb begin
      h_nxt = h_cnt + 12'd1;
      v_nxt = v_cnt;
      if (h_cnt == H_LAST) begin
         h_nxt = '0;
         v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 12'd1;
      end
   end

   // Outputs are decoded from the position about to be entered, so every
   // register describes the same pixel as the counters after the edge.
   always_comb begin
      act_nxt = in_window(h_nxt, 13'd0, H_ACT_END) && in_window(v_nxt, 13'd0, V_ACT_END);
      hs_nxt  = in_window(h_nxt, HS_BEG, HS_END);
      vs_nxt  = in_window(v_nxt, VS_BEG, VS_END);
      fs_nxt  = (h_nxt == 12'd0) && (v_nxt == 12'd0);
   end

   // Raster counters; reset parks them on the last pixel so release lands on (0,0).
   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt <= H_LAST;
         v_cnt <= V_LAST;
      end else begin
         h_cnt <= h_nxt;
         v_cnt <= v_nxt;
      end
   end

   // Stage p0: coordinates, active flag, frame start, internal syncs, channel latch.
   always_ff @(posedge clk) begin
      if (rst) begin
         px_x           <= '0;
         px_y           <= '0;
         data_en        <= 1'b0;
         frame_start    <= 1'b0;
         channel_select <= '0;
         hsync_p0       <= SYNC_OFF;
         vsync_p0       <= SYNC_OFF;
      end else begin
         px_x        <= h_nxt;
         px_y        <= v_nxt;
         data_en     <= act_nxt;
         frame_start <= fs_nxt;
         hsync_p0    <= hs_nxt ? SYNC_ON : SYNC_OFF;
         vsync_p0    <= vs_nxt ? SYNC_ON : SYNC_OFF;
         if (fs_nxt) begin
            channel_select <= channel_select_in;
         end
      end
   end

   // Stage p1: HDMI sync/de one clock later, matching the colour stage latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         hdmi_hsync <= SYNC_OFF;
         hdmi_vsync <= SYNC_OFF;
         hdmi_de    <= 1'b0;
      end else begin
         hdmi_hsync <= hsync_p0;
         hdmi_vsync <= vsync_p0;
         hdmi_de    <= data_en;
      end
   end

endmodule

// File: tb/tb_hdmi_video_timing.sv
// Testbench for hdmi_video_timing: instance A uses the full 1280-wide line timing
// with a short frame, instance B uses tiny timing with active-low syncs. Both are
// checked every cycle against a position-index model of the raster.
`timescale 1ns/1ps
module tb_hdmi_video_timing;

   localparam int AHA = 1280, AHF = 110, AHS = 40, AHB = 220;
   localparam int AVA = 4, AVF = 1, AVS = 1, AVB = 1;
   localparam int AHT = AHA + AHF + AHS + AHB;
   localparam int AVT = AVA + AVF + AVS + AVB;
   localparam int AFT = AHT * AVT;
   localparam int BHA = 8, BHF = 2, BHS = 2, BHB = 2;
   localparam int BVA = 4, BVF = 1, BVS = 1, BVB = 1;
   localparam int BHT = BHA + BHF + BHS + BHB;
   localparam int BVT = BVA + BVF + BVS + BVB;
   localparam int BFT = BHT * BVT;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [1:0] chan_in = 2'd0;
   always #5 clk = ~clk;

   logic [11:0] px_x_a, px_y_a, px_x_b, px_y_b;
   logic data_en_a, frame_start_a, hdmi_hsync_a, hdmi_vsync_a, hdmi_de_a;
   logic data_en_b, frame_start_b, hdmi_hsync_b, hdmi_vsync_b, hdmi_de_b;
   logic [1:0] channel_select_a, channel_select_b;

   hdmi_video_timing #(.H_ACTIVE(AHA), .H_FP(AHF), .H_SYNC(AHS), .H_BP(AHB),
                       .V_ACTIVE(AVA), .V_FP(AVF), .V_SYNC(AVS), .V_BP(AVB),
                       .SYNC_POL(1)) dut_a (
      .clk(clk), .rst(rst), .channel_select_in(chan_in),
      .px_x(px_x_a), .px_y(px_y_a), .data_en(data_en_a), .frame_start(frame_start_a),
      .channel_select(channel_select_a), .hdmi_hsync(hdmi_hsync_a),
      .hdmi_vsync(hdmi_vsync_a), .hdmi_de(hdmi_de_a));

   hdmi_video_timing #(.H_ACTIVE(BHA), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
                       .V_ACTIVE(BVA), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB),
                       .SYNC_POL(0)) dut_b (
      .clk(clk), .rst(rst), .channel_select_in(chan_in),
      .px_x(px_x_b), .px_y(px_y_b), .data_en(data_en_b), .frame_start(frame_start_b),
      .channel_select(channel_select_b), .hdmi_hsync(hdmi_hsync_b),
      .hdmi_vsync(hdmi_vsync_b), .hdmi_de(hdmi_de_b));

   wire [30:0] act_a = {px_x_a, px_y_a, data_en_a, frame_start_a, channel_select_a,
                        hdmi_hsync_a, hdmi_vsync_a, hdmi_de_a};
   wire [30:0] act_b = {px_x_b, px_y_b, data_en_b, frame_start_b, channel_select_b,
                        hdmi_hsync_b, hdmi_vsync_b, hdmi_de_b};

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [11:0] x;
      logic [11:0] y;
      logic        de;
      logic        fs;
      logic        hs;
      logic        vs;
   } pt_t;

   // Pixel p (counted from reset release) of a raster; p < 0 means "in reset".
   function automatic pt_t ref_pt(input int p, input int ha, input int hf, input int hs,
                                  input int ht, input int va, input int vf, input int vs,
                                  input int vt, input logic pol);
      pt_t r;
      int x, y;
      if (p < 0) begin
         r = '{x: 12'd0, y: 12'd0, de: 1'b0, fs: 1'b0, hs: ~pol, vs: ~pol};
         return r;
      end
      x = p % ht;
      y = (p / ht) % vt;
      r.x  = 12'(x);
      r.y  = 12'(y);
      r.de = (x < ha) && (y < va);
      r.fs = (x == 0) && (y == 0);
      r.hs = (x >= ha + hf && x < ha + hf + hs) ? pol : ~pol;
      r.vs = (y >= va + vf && y < va + vf + vs) ? pol : ~pol;
      return r;
   endfunction

   function automatic pt_t ref_a(input int p);
      return ref_pt(p, AHA, AHF, AHS, AHT, AVA, AVF, AVS, AVT, 1'b1);
   endfunction

   function automatic pt_t ref_b(input int p);
      return ref_pt(p, BHA, BHF, BHS, BHT, BVA, BVF, BVS, BVT, 1'b0);
   endfunction

   int pos = -1;
   pt_t cur_a, cur_b;
   logic [1:0] ch_a = 2'd0, ch_b = 2'd0;
   logic [30:0] exp_a, exp_b;

   // Advance one clock and update the model from the inputs present at the edge.
   task automatic tick();
      logic rst_s;
      logic [1:0] ch_s;
      pt_t pa, pb;
      rst_s = rst;
      ch_s  = chan_in;
      @(posedge clk);
      #1;
      pos   = rst_s ? -1 : pos + 1;
      cur_a = ref_a(pos);
      cur_b = ref_b(pos);
      pa    = ref_a(pos <= 0 ? -1 : pos - 1);
      pb    = ref_b(pos <= 0 ? -1 : pos - 1);
      if (rst_s) begin
         ch_a = 2'd0;
         ch_b = 2'd0;
      end else begin
         if (cur_a.fs) ch_a = ch_s;
         if (cur_b.fs) ch_b = ch_s;
      end
      exp_a = {cur_a.x, cur_a.y, cur_a.de, cur_a.fs, ch_a, pa.hs, pa.vs, pa.de};
      exp_b = {cur_b.x, cur_b.y, cur_b.de, cur_b.fs, ch_b, pb.hs, pb.vs, pb.de};
   endtask

   task automatic test_reset();
      rst = 1'b1;
      chan_in = 2'd3;
      repeat (3) begin
         tick();
         checks++;
         if ({act_a, act_b} !== {exp_a, exp_b}) begin
            errors++;
            $display("FAIL reset_hold act_a=%h exp_a=%h act_b=%h exp_b=%h", act_a, exp_a, act_b, exp_b);
         end
      end
      checks++;
      if ({hdmi_hsync_a, hdmi_vsync_a, hdmi_hsync_b, hdmi_vsync_b, channel_select_a} !== 6'b001100) begin
         errors++;
         $display("FAIL reset_sync_level got=%b%b%b%b ch=%0d want=0011 ch=0",
                  hdmi_hsync_a, hdmi_vsync_a, hdmi_hsync_b, hdmi_vsync_b, channel_select_a);
      end
      chan_in = 2'($urandom_range(1, 3));
      rst = 1'b0;
      tick();
      checks++;
      if ({px_x_a, px_y_a, data_en_a, frame_start_a, channel_select_a} !== {24'd0, 1'b1, 1'b1, chan_in}) begin
         errors++;
         $display("FAIL first_pixel x=%0d y=%0d de=%b fs=%b ch=%0d want x=0 y=0 de=1 fs=1 ch=%0d",
                  px_x_a, px_y_a, data_en_a, frame_start_a, channel_select_a, chan_in);
      end
      tick();
      checks++;
      if ({hdmi_de_a, frame_start_a} !== 2'b10) begin
         errors++;
         $display("FAIL second_pixel hdmi_de=%b fs=%b want hdmi_de=1 fs=0", hdmi_de_a, frame_start_a);
      end
      checks++;
      if ({act_a, act_b} !== {exp_a, exp_b}) begin
         errors++;
         $display("FAIL raster_after_release act_a=%h exp_a=%h act_b=%h exp_b=%h", act_a, exp_a, act_b, exp_b);
      end
   endtask

   task automatic test_line_timing();
      int de_n = 0, hs_n = 0, rise_x = -1, line_y;
      logic prev_hs;
      logic [11:0] prev_x;
      for (int i = 0; i < 2 * AHT && cur_a.x != 12'(AHT - 1); i++) begin
         chan_in = 2'($urandom_range(0, 3));
         tick();
         checks++;
         if ({act_a, act_b} !== {exp_a, exp_b}) begin
            errors++;
            $display("FAIL raster pos=%0d act_a=%h exp_a=%h act_b=%h exp_b=%h", pos, act_a, exp_a, act_b, exp_b);
         end
      end
      line_y = int'(cur_a.y) + 1;
      for (int i = 0; i < AHT; i++) begin
         prev_x  = px_x_a;
         prev_hs = hdmi_hsync_a;
         chan_in = 2'($urandom_range(0, 3));
         tick();
         checks++;
         if ({act_a, act_b} !== {exp_a, exp_b}) begin
            errors++;
            $display("FAIL raster pos=%0d act_a=%h exp_a=%h act_b=%h exp_b=%h", pos, act_a, exp_a, act_b, exp_b);
         end
         if (data_en_a) de_n++;
         if (hdmi_hsync_a) hs_n++;
         if (hdmi_hsync_a && !prev_hs && rise_x < 0) rise_x = int'(prev_x);
      end
      checks++;
      if (de_n != AHA) begin
         errors++;
         $display("FAIL line_de_count got=%0d want=%0d", de_n, AHA);
      end
      checks++;
      if (hs_n != AHS) begin
         errors++;
         $display("FAIL line_hsync_width got=%0d want=%0d", hs_n, AHS);
      end
      checks++;
      if (rise_x != AHA + AHF) begin
         errors++;
         $display("FAIL hsync_rise_after_x got=%0d want=%0d", rise_x, AHA + AHF);
      end
      tick();
      checks++;
      if (px_x_a !== 12'd0 || px_y_a !== 12'(line_y + 1)) begin
         errors++;
         $display("FAIL line_wrap got x=%0d y=%0d want x=0 y=%0d", px_x_a, px_y_a, line_y + 1);
      end
   endtask

   task automatic test_frame_timing();
      int vs_n = 0, de_n = 0, fs_n = 0, late_de = 0, rise_x = -1, rise_y = -1;
      logic prev_vs;
      logic [11:0] prev_x, prev_y;
      for (int i = 0; i < 2 * AFT && !cur_a.fs; i++) begin
         chan_in = 2'($urandom_range(0, 3));
         tick();
         checks++;
         if ({act_a, act_b} !== {exp_a, exp_b}) begin
            errors++;
            $display("FAIL raster pos=%0d act_a=%h exp_a=%h act_b=%h exp_b=%h", pos, act_a, exp_a, act_b, exp_b);
         end
      end
      for (int i = 1; i <= AFT; i++) begin
         prev_x  = px_x_a;
         prev_y  = px_y_a;
         prev_vs = hdmi_vsync_a;
         chan_in = 2'($urandom_range(0, 3));
         tick();
         checks++;
         if ({act_a, act_b} !== {exp_a, exp_b}) begin
            errors++;
            $display("FAIL raster pos=%0d act_a=%h exp_a=%h act_b=%h exp_b=%h", pos, act_a, exp_a, act_b, exp_b);
         end
         if (hdmi_vsync_a) vs_n++;
         if (data_en_a) de_n++;
         if (frame_start_a) fs_n++;
         if (data_en_a && px_y_a >= 12'(AVA)) late_de++;
         if (hdmi_vsync_a && !prev_vs && rise_x < 0) begin
            rise_x = int'(prev_x);
            rise_y = int'(prev_y);
         end
      end
      checks++;
      if (fs_n != 1 || frame_start_a !== 1'b1) begin
         errors++;
         $display("FAIL frame_period starts=%0d fs_at_end=%b want starts=1 fs_at_end=1", fs_n, frame_start_a);
      end
      checks++;
      if (vs_n != AVS * AHT) begin
         errors++;
         $display("FAIL vsync_width got=%0d want=%0d", vs_n, AVS * AHT);
      end
      checks++;
      if (rise_x != 0 || rise_y != AVA + AVF) begin
         errors++;
         $display("FAIL vsync_rise_after got=(%0d,%0d) want=(0,%0d)", rise_x, rise_y, AVA + AVF);
      end
      checks++;
      if (de_n != AVA * AHA || late_de != 0) begin
         errors++;
         $display("FAIL frame_de got=%0d late=%0d want=%0d late=0", de_n, late_de, AVA * AHA);
      end
   endtask

   task automatic test_channel_latch();
      int held_bad = 0;
      chan_in = 2'd0;
      tick();
      for (int i = 0; i < 2 * AFT && !cur_a.fs; i++) begin
         tick();
         checks++;
         if ({act_a, act_b} !== {exp_a, exp_b}) begin
            errors++;
            $display("FAIL raster pos=%0d act_a=%h exp_a=%h act_b=%h exp_b=%h", pos, act_a, exp_a, act_b, exp_b);
         end
      end
      checks++;
      if (channel_select_a !== 2'd0) begin
         errors++;
         $display("FAIL chan_load_zero got=%0d want=0", channel_select_a);
      end
      for (int i = 0; i < 2 * AFT && !(cur_a.x == 12'd500 && cur_a.y == 12'd2); i++) tick();
      chan_in = 2'd2;
      for (int i = 0; i < 2 * AFT; i++) begin
         tick();
         checks++;
         if ({act_a, act_b} !== {exp_a, exp_b}) begin
            errors++;
            $display("FAIL raster pos=%0d act_a=%h exp_a=%h act_b=%h exp_b=%h", pos, act_a, exp_a, act_b, exp_b);
         end
         if (cur_a.fs) break;
         if (channel_select_a !== 2'd0) held_bad++;
      end
      checks++;
      if (held_bad != 0) begin
         errors++;
         $display("FAIL chan_mid_frame_hold changed_cycles=%0d want=0", held_bad);
      end
      checks++;
      if (channel_select_a !== 2'd2 || frame_start_a !== 1'b1) begin
         errors++;
         $display("FAIL chan_new_frame got ch=%0d fs=%b want ch=2 fs=1", channel_select_a, frame_start_a);
      end
   endtask

   task automatic test_mid_reset();
      int hs_bad = 0;
      for (int i = 0; i < 2 * AFT && !(cur_a.x == 12'd800 && cur_a.y == 12'd2); i++) begin
         chan_in = 2'($urandom_range(0, 3));
         tick();
      end
      rst = 1'b1;
      repeat (3) begin
         tick();
         checks++;
         if ({px_x_a, px_y_a, data_en_a, frame_start_a, channel_select_a, hdmi_hsync_a, hdmi_vsync_a, hdmi_de_a} !== 31'd0
             || {act_b} !== exp_b) begin
            errors++;
            $display("FAIL mid_reset_values act_a=%h want=0 act_b=%h exp_b=%h", act_a, act_b, exp_b);
         end
      end
      rst = 1'b0;
      tick();
      checks++;
      if ({px_x_a, px_y_a, data_en_a, frame_start_a} !== {24'd0, 2'b11}) begin
         errors++;
         $display("FAIL restart_pixel x=%0d y=%0d de=%b fs=%b want 0 0 1 1", px_x_a, px_y_a, data_en_a, frame_start_a);
      end
      for (int i = 0; i < AHT && cur_a.x != 12'(AHA + AHF); i++) begin
         chan_in = 2'($urandom_range(0, 3));
         tick();
         checks++;
         if ({act_a, act_b} !== {exp_a, exp_b}) begin
            errors++;
            $display("FAIL raster pos=%0d act_a=%h exp_a=%h act_b=%h exp_b=%h", pos, act_a, exp_a, act_b, exp_b);
         end
         if (hdmi_hsync_a !== 1'b0) hs_bad++;
      end
      checks++;
      if (hs_bad != 0) begin
         errors++;
         $display("FAIL restart_sync_quiet active_cycles=%0d want=0", hs_bad);
      end
      tick();
      checks++;
      if (hdmi_hsync_a !== 1'b1) begin
         errors++;
         $display("FAIL restart_hsync_rise got=%b want=1", hdmi_hsync_a);
      end
   endtask

   task automatic test_small_pol0();
      int hs_low = 0, vs_low = 0, fs_n = 0, wrap_bad = 0, max_x = 0, max_y = 0;
      logic [11:0] prev_x, prev_y;
      for (int i = 0; i < 2 * BFT && !cur_b.fs; i++) tick();
      for (int i = 0; i < 3 * BFT; i++) begin
         prev_x  = px_x_b;
         prev_y  = px_y_b;
         chan_in = 2'($urandom_range(0, 3));
         tick();
         checks++;
         if ({act_a, act_b} !== {exp_a, exp_b}) begin
            errors++;
            $display("FAIL raster pos=%0d act_a=%h exp_a=%h act_b=%h exp_b=%h", pos, act_a, exp_a, act_b, exp_b);
         end
         if (!hdmi_hsync_b) hs_low++;
         if (!hdmi_vsync_b) vs_low++;
         if (frame_start_b) fs_n++;
         if (int'(px_x_b) > max_x) max_x = int'(px_x_b);
         if (int'(px_y_b) > max_y) max_y = int'(px_y_b);
         if (prev_x == 12'(BHT - 1) &&
             (px_x_b !== 12'd0 || int'(px_y_b) != (int'(prev_y) + 1) % BVT)) wrap_bad++;
      end
      checks++;
      if (hs_low != 3 * BVT * BHS || vs_low != 3 * BVS * BHT) begin
         errors++;
         $display("FAIL pol0_sync_low hs=%0d vs=%0d want hs=%0d vs=%0d", hs_low, vs_low, 3 * BVT * BHS, 3 * BVS * BHT);
      end
      checks++;
      if (fs_n != 3 || wrap_bad != 0 || max_x != BHT - 1 || max_y != BVT - 1) begin
         errors++;
         $display("FAIL pol0_wrap starts=%0d bad_wraps=%0d max_x=%0d max_y=%0d want 3 0 %0d %0d",
                  fs_n, wrap_bad, max_x, max_y, BHT - 1, BVT - 1);
      end
   endtask

   initial begin
      test_reset();
      test_line_timing();
      test_frame_timing();
      test_channel_latch();
      test_mid_reset();
      test_small_pol0();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
